// File: rtl/cache_fill_arbiter.sv
// rtl/cache_fill_arbiter.sv - round-robin cache miss fill and write-through store arbiter
module cache_fill_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int NUM_CH = 2,
    parameter int WORDS  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        miss_req,
    input  logic [NUM_CH*ADDR_W-1:0] miss_addr,
    input  logic                     wr_req,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ack,
    output logic                     mem_en,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_rvalid,
    output logic [NUM_CH-1:0]        fill_data_we,
    output logic [NUM_CH-1:0]        fill_tag_we,
    output logic [$clog2(WORDS)-1:0] fill_word,
    output logic [DATA_W-1:0]        fill_data,
    output logic [NUM_CH-1:0]        stall,
    output logic                     busy
);

    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WORD_W = $clog2(WORDS);
    localparam int CNT_W  = WORD_W + 1;
    localparam logic [CNT_W-1:0]  CNT_WORDS = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0] BLK_MASK  = ADDR_W'(2 * WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE, WRITE} state_t;

    state_t             state, state_n;
    logic [CH_W-1:0]    rr_ptr, rr_n;
    logic [CH_W-1:0]    grant, grant_n;
    logic [ADDR_W-1:0]  base, base_n;
    logic [CNT_W-1:0]   issue_cnt, issue_n;
    logic [CNT_W-1:0]   ret_cnt, ret_n;
    logic [CH_W-1:0]    pick, hi_pick, lo_pick;
    logic               hi_found;
    logic [ADDR_W-1:0]  sel_addr;
    logic [NUM_CH-1:0]  grant_oh;

    // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest requester.
    always_comb begin
        hi_pick  = '0;
        lo_pick  = '0;
        hi_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (miss_req[i]) begin
                lo_pick = CH_W'(i);
                if (CH_W'(i) >= rr_ptr) begin
                    hi_pick  = CH_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        pick = hi_found ? hi_pick : lo_pick;
        sel_addr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pick == CH_W'(i)) sel_addr = miss_addr[i*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            grant_oh[i] = (grant == CH_W'(i));
            stall[i]    = miss_req[i] | (busy & grant_oh[i]);
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            base      <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_n;
            grant     <= grant_n;
            base      <= base_n;
            issue_cnt <= issue_n;
            ret_cnt   <= ret_n;
        end
    end

    always_comb begin
        state_n      = state;
        rr_n         = rr_ptr;
        grant_n      = grant;
        base_n       = base;
        issue_n      = issue_cnt;
        ret_n        = ret_cnt;
        mem_en       = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        wr_ack       = 1'b0;
        fill_data_we = '0;
        fill_tag_we  = '0;
        fill_word    = '0;
        fill_data    = '0;
        case (state)
            IDLE: begin
                if (|miss_req) begin
                    grant_n = pick;
                    base_n  = sel_addr & ~BLK_MASK;
                    issue_n = '0;
                    ret_n   = '0;
                    state_n = FILL;
                end else if (wr_req) begin
                    state_n = WRITE;
                end
            end
            FILL: begin
                if (issue_cnt < CNT_WORDS) begin
                    mem_en   = 1'b1;
                    mem_addr = base + ADDR_W'({issue_cnt, 1'b0});
                    issue_n  = issue_cnt + 1'b1;
                end
                // Returns are written straight through so the cache sees data the cycle it arrives.
                if (mem_rvalid) begin
                    fill_data_we = grant_oh;
                    fill_word    = ret_cnt[WORD_W-1:0];
                    fill_data    = mem_rdata;
                    ret_n        = ret_cnt + 1'b1;
                    if (ret_cnt == CNT_LAST) begin
                        fill_tag_we = grant_oh;
                        state_n     = DONE;
                    end
                end
            end
            DONE: begin
                rr_n    = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
                state_n = IDLE;
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_write = 1'b1;
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
                wr_ack    = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// tb/tb_cache_fill_arbiter.sv - self-checking bench for cache_fill_arbiter
module tb_cache_fill_arbiter;

    localparam int L = 2;
    localparam int W = 8;
    localparam int N = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  miss_req;
    logic [31:0] miss_addr;
    logic        wr_req;
    logic [15:0] wr_addr, wr_data;
    logic        wr_ack, mem_en, mem_write, busy;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
    logic        mem_rvalid;
    logic [1:0]  fill_data_we, fill_tag_we, stall;
    logic [2:0]  fill_word;

    logic [3:0]  b_miss, b_dwe, b_twe, b_stall, b_word;
    logic [63:0] b_maddr;
    logic        b_wreq, b_ack, b_en, b_mw, b_rv, b_busy;
    logic [15:0] b_wa, b_wd, b_a, b_mwd, b_rd, b_fd;

    logic        o_miss, o_dwe, o_twe, o_stall, o_wreq, o_ack, o_en, o_mw, o_rv, o_busy;
    logic [15:0] o_maddr, o_wa, o_wd, o_a, o_mwd, o_rd, o_fd;
    logic [1:0]  o_word;

    always #5 clk = ~clk;

    cache_fill_arbiter u_dut (
        .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .fill_data_we(fill_data_we),
        .fill_tag_we(fill_tag_we), .fill_word(fill_word), .fill_data(fill_data),
        .stall(stall), .busy(busy)
    );

    cache_fill_arbiter #(.NUM_CH(4), .WORDS(16)) u_big (
        .clk(clk), .rst(rst), .miss_req(b_miss), .miss_addr(b_maddr),
        .wr_req(b_wreq), .wr_addr(b_wa), .wr_data(b_wd), .wr_ack(b_ack),
        .mem_en(b_en), .mem_write(b_mw), .mem_addr(b_a), .mem_wdata(b_mwd),
        .mem_rdata(b_rd), .mem_rvalid(b_rv), .fill_data_we(b_dwe),
        .fill_tag_we(b_twe), .fill_word(b_word), .fill_data(b_fd),
        .stall(b_stall), .busy(b_busy)
    );

    cache_fill_arbiter #(.NUM_CH(1), .WORDS(4)) u_one (
        .clk(clk), .rst(rst), .miss_req(o_miss), .miss_addr(o_maddr),
        .wr_req(o_wreq), .wr_addr(o_wa), .wr_data(o_wd), .wr_ack(o_ack),
        .mem_en(o_en), .mem_write(o_mw), .mem_addr(o_a), .mem_wdata(o_mwd),
        .mem_rdata(o_rd), .mem_rvalid(o_rv), .fill_data_we(o_dwe),
        .fill_tag_we(o_twe), .fill_word(o_word), .fill_data(o_fd),
        .stall(o_stall), .busy(o_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Pipelined memories: read data is the address scrambled with a fixed pattern.
    bit          pipe_v[L];
    logic [15:0] pipe_a[L];
    logic        req_s, inj;
    logic [15:0] addr_s;
    logic        b_req_s, o_req_s;
    logic [15:0] b_as, o_as;

    always @(posedge clk) begin
        #2;
        for (int k = L - 1; k > 0; k--) begin
            pipe_v[k] = pipe_v[k-1];
            pipe_a[k] = pipe_a[k-1];
        end
        pipe_v[0] = (req_s === 1'b1) && rst;
        pipe_a[0] = addr_s;
        if (!rst) for (int k = 0; k < L; k++) pipe_v[k] = 1'b0;
        mem_rvalid = pipe_v[L-1] | inj;
        mem_rdata  = pipe_v[L-1] ? (pipe_a[L-1] ^ 16'h5A5A) : 16'hDEAD;
        b_rv = (b_req_s === 1'b1) && rst;
        b_rd = b_as ^ 16'h3C3C;
        o_rv = (o_req_s === 1'b1) && rst;
        o_rd = o_as ^ 16'h3C3C;
    end

    // Transaction-level model: a grant schedules a fill window, a store schedules one write cycle.
    int          cyc = 0;
    int          m_start = 0, m_free = 0, m_fs = 0, m_g = 0, m_rr = 0, m_ret = 0;
    bit          m_isfill = 0;
    logic [15:0] m_base = 16'h0;

    logic [15:0] rd_q[$];
    int          words_q[$], tag_ch_q[$];
    int          we_cnt, tag_cnt, tag_word, tag_cyc, wr_cnt, wr_cyc, busy_cyc;
    logic [15:0] wr_a, wr_d;
    logic [1:0]  tag_val;

    always @(negedge clk) begin : model
        logic        e_en, e_wr, e_ack, e_busy;
        logic [15:0] e_addr, e_wdata, e_data;
        logic [1:0]  e_we, e_tag, e_stall;
        logic [2:0]  e_word;
        bit          found;
        int          c;
        cyc++;
        req_s = mem_en & ~mem_write;  addr_s = mem_addr;
        b_req_s = b_en & ~b_mw;       b_as = b_a;
        o_req_s = o_en & ~o_mw;       o_as = o_a;
        {e_en, e_wr, e_ack, e_busy} = '0;
        {e_addr, e_wdata, e_data} = '0;
        {e_we, e_tag, e_stall, e_word} = '0;
        if (rst) begin
            e_busy = (cyc >= m_start) && (cyc < m_free);
            if (e_busy && m_isfill) begin
                if (cyc < m_fs + W) begin
                    e_en   = 1'b1;
                    e_addr = m_base + 16'(2 * (cyc - m_fs));
                end
                if (mem_rvalid && cyc < m_free - 1) begin
                    e_we   = 2'(1 << m_g);
                    e_word = 3'(m_ret);
                    e_data = (m_base + 16'(2 * m_ret)) ^ 16'h5A5A;
                    if (m_ret == W - 1) e_tag = e_we;
                end
            end else if (e_busy) begin
                {e_en, e_wr, e_ack} = 3'b111;
                e_addr  = wr_addr;
                e_wdata = wr_data;
            end
            if (e_busy) e_stall = 2'(1 << m_g);
        end
        e_stall = e_stall | miss_req;
        chk($sformatf("busy c%0d", cyc), busy, e_busy);
        chk($sformatf("mem_en c%0d", cyc), mem_en, e_en);
        chk($sformatf("mem_write c%0d", cyc), mem_write, e_wr);
        chk($sformatf("mem_addr c%0d", cyc), mem_addr, e_addr);
        chk($sformatf("mem_wdata c%0d", cyc), mem_wdata, e_wdata);
        chk($sformatf("wr_ack c%0d", cyc), wr_ack, e_ack);
        chk($sformatf("fill_data_we c%0d", cyc), fill_data_we, e_we);
        chk($sformatf("fill_tag_we c%0d", cyc), fill_tag_we, e_tag);
        chk($sformatf("fill_word c%0d", cyc), fill_word, e_word);
        chk($sformatf("fill_data c%0d", cyc), fill_data, e_data);
        chk($sformatf("stall c%0d", cyc), stall, e_stall);
        if (rst) begin
            if (mem_en && !mem_write) rd_q.push_back(mem_addr);
            if (mem_en && mem_write) begin wr_cnt++; wr_a = mem_addr; wr_d = mem_wdata; wr_cyc = cyc; end
            if (|fill_data_we) begin we_cnt++; words_q.push_back(int'(fill_word)); end
            if (|fill_tag_we) begin
                tag_cnt++; tag_word = int'(fill_word); tag_val = fill_tag_we; tag_cyc = cyc;
                tag_ch_q.push_back(fill_tag_we[1] ? 1 : 0);
            end
            if (busy) busy_cyc++;
            if (e_we != 0) m_ret++;
            if (cyc >= m_free) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    c = (m_rr + k) % N;
                    if (!found && miss_req[c]) begin found = 1; m_g = c; end
                end
                if (found) begin
                    m_base = miss_addr[m_g*16 +: 16] & ~16'(2 * W - 1);
                    m_fs = cyc + 1; m_start = cyc + 1; m_free = cyc + W + L + 2;
                    m_isfill = 1; m_ret = 0; m_rr = (m_g + 1) % N;
                end else if (wr_req) begin
                    m_start = cyc + 1; m_free = cyc + 2; m_isfill = 0;
                end
            end
        end else begin
            m_start = 0; m_free = 0; m_rr = 0; m_g = 0; m_isfill = 0; m_ret = 0;
        end
    end

    task automatic clr_mon();
        rd_q.delete(); words_q.delete(); tag_ch_q.delete();
        we_cnt = 0; tag_cnt = 0; tag_word = -1; tag_cyc = 0; wr_cnt = 0; wr_cyc = 0; busy_cyc = 0;
        tag_val = 2'b00; wr_a = 16'h0; wr_d = 16'h0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_tag(input int ch);
        int n;
        for (n = 0; n < 100; n++) begin
            @(negedge clk); #1;
            if (fill_tag_we[ch]) break;
        end
        chk($sformatf("tag_wait ch%0d", ch), n < 100, 1);
        tick();
        miss_req[ch] = 1'b0;
    endtask

    task automatic wait_ack();
        int n;
        for (n = 0; n < 100; n++) begin
            @(negedge clk); #1;
            if (wr_ack) break;
        end
        chk("ack_wait", n < 100, 1);
        tick();
        wr_req = 1'b0;
    endtask

    initial begin
        int n, n_rd, n_ret, o_rdn, o_retn;
        bit got_b, got_o;
        logic [15:0] b_last;
        rst = 1'b0; miss_req = 2'b00; miss_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0; inj = 1'b0;
        b_miss = '0; b_maddr = '0; b_wreq = 1'b0; b_wa = '0; b_wd = '0;
        o_miss = 1'b0; o_maddr = '0; o_wreq = 1'b0; o_wa = '0; o_wd = '0;
        clr_mon();
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_fill_word", fill_word, 0);
        rst = 1'b1;
        tick();

        clr_mon();
        miss_addr[15:0] = 16'h1234; miss_req = 2'b01;
        wait_tag(0);
        repeat (3) tick();
        chk("t1_reads", rd_q.size(), 8);
        chk("t1_rd_first", rd_q[0], 16'h1230);
        chk("t1_rd_last", rd_q[7], 16'h123E);
        chk("t1_word_first", words_q[0], 0);
        chk("t1_word_last", words_q[7], 7);
        chk("t1_tag_cnt", tag_cnt, 1);
        chk("t1_tag_word", tag_word, 7);
        chk("t1_tag_val", tag_val, 2'b01);
        chk("t1_busy_cycles", busy_cyc, 11);

        rst = 1'b0; tick(); rst = 1'b1; tick();
        for (int rep = 0; rep < 2; rep++) begin
            clr_mon();
            miss_addr = {16'h2222, 16'h0100}; miss_req = 2'b11;
            wait_tag(0);
            wait_tag(1);
            repeat (2) tick();
            chk("rr_fills", tag_ch_q.size(), 2);
            chk("rr_first", tag_ch_q[0], 0);
            chk("rr_second", tag_ch_q[1], 1);
            chk("rr_rd_ch0", rd_q[0], 16'h0100);
            chk("rr_rd_ch1", rd_q[8], 16'h2220);
        end

        clr_mon();
        miss_addr[31:16] = 16'h3456; miss_req = 2'b10;
        wr_addr = 16'h00A0; wr_data = 16'hBEEF; wr_req = 1'b1;
        wait_tag(1);
        wait_ack();
        repeat (2) tick();
        chk("wr_count", wr_cnt, 1);
        chk("wr_addr", wr_a, 16'h00A0);
        chk("wr_data", wr_d, 16'hBEEF);
        chk("wr_after_fill", wr_cyc - tag_cyc, 3);
        chk("wr_tag_val", tag_val, 2'b10);

        clr_mon();
        inj = 1'b1; tick(); inj = 1'b0;
        wr_addr = 16'h0010; wr_data = 16'h1111; wr_req = 1'b1;
        tick(); inj = 1'b1;
        tick(); inj = 1'b0; wr_req = 1'b0;
        repeat (2) tick();
        chk("spur_no_we", we_cnt, 0);
        chk("spur_wr_count", wr_cnt, 1);
        chk("spur_wr_data", wr_d, 16'h1111);
        clr_mon();
        miss_addr[15:0] = 16'h5678; miss_req = 2'b01;
        wait_tag(0);
        repeat (2) tick();
        chk("spur_rd_first", rd_q[0], 16'h5670);
        chk("spur_word_first", words_q[0], 0);
        chk("spur_we_cnt", we_cnt, 8);
        chk("spur_tag_word", tag_word, 7);

        clr_mon();
        miss_addr[15:0] = 16'h4000; miss_req = 2'b01;
        for (n = 0; n < 60; n++) begin
            @(negedge clk); #1;
            if ((|fill_data_we) && fill_word == 3'd3) break;
        end
        chk("abort_wait", n < 60, 1);
        #1 rst = 1'b0;
        #1;
        chk("abort_we", fill_data_we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_mem_en", mem_en, 0);
        chk("abort_fill_word", fill_word, 0);
        chk("abort_fill_data", fill_data, 0);
        tick(); tick();
        chk("abort_no_tag", tag_cnt, 0);
        clr_mon();
        rst = 1'b1;
        wait_tag(0);
        repeat (2) tick();
        chk("restart_rd_first", rd_q[0], 16'h4000);
        chk("restart_word_first", words_q[0], 0);
        chk("restart_tag_cnt", tag_cnt, 1);

        b_maddr[63:48] = 16'hFFF0; b_miss = 4'b1000;
        o_maddr = 16'h0047; o_miss = 1'b1;
        n_rd = 0; n_ret = 0; o_rdn = 0; o_retn = 0; got_b = 0; got_o = 0; b_last = '0;
        for (int i = 0; i < 80 && !(got_b && got_o); i++) begin
            @(negedge clk); #1;
            if (!got_b) begin
                if (b_en) begin
                    chk("big_rd_addr", b_a, 16'hFFE0 + 16'(2 * n_rd));
                    b_last = b_a; n_rd++;
                end
                if (|b_dwe) begin
                    chk("big_we", b_dwe, 4'b1000);
                    chk("big_word", b_word, n_ret);
                    chk("big_data", b_fd, (16'hFFE0 + 16'(2 * n_ret)) ^ 16'h3C3C);
                    n_ret++;
                end
                if (|b_twe) begin
                    chk("big_tag", b_twe, 4'b1000);
                    chk("big_tag_word", b_word, 15);
                    got_b = 1; b_miss = 4'b0000;
                end
            end
            if (!got_o) begin
                if (o_en) begin
                    chk("one_rd_addr", o_a, 16'h0040 + 16'(2 * o_rdn));
                    o_rdn++;
                end
                if (o_dwe) begin
                    chk("one_word", o_word, o_retn);
                    chk("one_data", o_fd, (16'h0040 + 16'(2 * o_retn)) ^ 16'h3C3C);
                    o_retn++;
                end
                if (o_twe) begin
                    chk("one_tag_word", o_word, 3);
                    got_o = 1; o_miss = 1'b0;
                end
            end
        end
        chk("big_done", got_b, 1);
        chk("big_reads", n_rd, 16);
        chk("big_rd_last", b_last, 16'hFFFE);
        chk("one_done", got_o, 1);
        chk("one_reads", o_rdn, 4);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
